// File: rtl/vreg_agu_pkg.sv
// Shared types and constants for the vector-register AGU arbiter.
package vreg_agu_pkg;

    localparam int NREQ  = 3;
    localparam int VL_W  = 32;
    localparam int GID_W = 2;

    localparam logic [GID_W-1:0] RQ_VS1 = 2'd0;
    localparam logic [GID_W-1:0] RQ_VS2 = 2'd1;
    localparam logic [GID_W-1:0] RQ_VD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_pick
    import vreg_agu_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [GID_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [GID_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_req[(int'(i_ptr) + i) % N]) begin
                o_any                      = 1'b1;
                o_gnt[(int'(i_ptr) + i) % N] = 1'b1;
                o_idx                      = GID_W'((int'(i_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/vreg_agu_arb.sv
// Round-robin arbiter sharing one AGU among the vs1/vs2/vd burst requesters.
//   state   | meaning
//   S_IDLE  | no owner; pick and latch a requester when any is valid
//   S_ISSUE | agu_req_valid high with latched fields, waiting for agu_req_ready
//   S_BUSY  | burst accepted; responses routed to owner until agu_req_ready returns
module vreg_agu_arb #(
    parameter int NREQ = vreg_agu_pkg::NREQ,
    parameter int VL_W = vreg_agu_pkg::VL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      rq_valid,
    output logic [NREQ-1:0]      rq_ready,
    input  logic [NREQ*VL_W-1:0] rq_vl,
    input  logic [NREQ*5-1:0]    rq_vr,
    input  logic [NREQ-1:0]      rq_masked,
    input  logic [NREQ-1:0]      rq_s_value,
    output logic [NREQ-1:0]      rq_resp_valid,
    input  logic [NREQ-1:0]      rq_resp_ready,
    output logic [NREQ-1:0]      rq_done,
    output logic                 agu_req_valid,
    output logic [VL_W-1:0]      agu_vl,
    output logic [4:0]           agu_vr,
    output logic                 agu_masked,
    output logic                 agu_s_value,
    input  logic                 agu_req_ready,
    input  logic                 agu_resp_valid,
    output logic                 agu_resp_ready,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    import vreg_agu_pkg::*;

    state_t              r_state, w_next;
    logic [GID_W-1:0]    r_ptr, r_grant_id;
    logic [VL_W-1:0]     r_vl;
    logic [4:0]          r_vr;
    logic                r_masked, r_s_value, r_agu_req_valid, r_busy;
    logic [NREQ-1:0]     r_rq_ready, r_rq_done;

    logic [NREQ-1:0]     w_gnt, w_own;
    logic [GID_W-1:0]    w_idx;
    logic                w_any, w_granted;
    logic [VL_W-1:0]     w_vl_arr [NREQ];
    logic [4:0]          w_vr_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_vl_arr[g] = rq_vl[g*VL_W +: VL_W];
        assign w_vr_arr[g] = rq_vr[g*5 +: 5];
    end

    rr_pick #(.N(NREQ)) u_pick (
        .i_req (rq_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any)         w_next = S_ISSUE;
            S_ISSUE: if (agu_req_ready) w_next = S_BUSY;
            S_BUSY:  if (agu_req_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    assign w_own = {{(NREQ-1){1'b0}}, 1'b1} << r_grant_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_grant_id      <= '0;
            r_vl            <= '0;
            r_vr            <= '0;
            r_masked        <= 1'b0;
            r_s_value       <= 1'b0;
            r_agu_req_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_rq_ready      <= '0;
            r_rq_done       <= '0;
        end else begin
            r_state         <= w_next;
            r_agu_req_valid <= (w_next == S_ISSUE);
            r_busy          <= (w_next != S_IDLE);
            r_rq_ready      <= (r_state == S_ISSUE && agu_req_ready) ? w_own : '0;
            r_rq_done       <= (r_state == S_BUSY && agu_req_ready) ? w_own : '0;
            if (r_state == S_IDLE && w_any) begin
                r_grant_id <= w_idx;
                r_vl       <= w_vl_arr[w_idx];
                r_vr       <= w_vr_arr[w_idx];
                r_masked   <= rq_masked[w_idx];
                r_s_value  <= rq_s_value[w_idx];
            end
            if (r_state == S_BUSY && agu_req_ready)
                r_ptr <= (int'(r_grant_id) == NREQ - 1) ? '0 : r_grant_id + 1'b1;
        end
    end

    // Response path is the only combinational route; it follows the owner directly.
    assign w_granted      = (r_state != S_IDLE);
    assign rq_resp_valid  = (w_granted && agu_resp_valid) ? w_own : '0;
    assign agu_resp_ready = w_granted && rq_resp_ready[r_grant_id];

    assign rq_ready      = r_rq_ready;
    assign rq_done       = r_rq_done;
    assign agu_req_valid = r_agu_req_valid;
    assign agu_vl        = r_vl;
    assign agu_vr        = r_vr;
    assign agu_masked    = r_masked;
    assign agu_s_value   = r_s_value;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;

    logic w_unused;
    assign w_unused = ^w_gnt;

endmodule

// File: doc/vreg_agu_arb.md
VREG_AGU_ARB -- requirements
Module: vreg_agu_arb

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing one AGU (0=vs1, 1=vs2, 2=vd).
REQ-002 Parameter VL_W, default 32, width of the vector-length field.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rq_valid  input  NREQ  per-requester burst request.
REQ-006 rq_ready  output  NREQ  one-cycle pulse when that requester's burst is handed to the AGU.
REQ-007 rq_vl  input  NREQ*VL_W  per-requester vector length, packed, requester 0 in LSBs.
REQ-008 rq_vr  input  NREQ*5  per-requester vector register index, packed.
REQ-009 rq_masked, rq_s_value  input  NREQ each  per-requester mode bits.
REQ-010 rq_resp_valid  output  NREQ  AGU resp_valid routed to the granted requester only.
REQ-011 rq_resp_ready  input  NREQ  per-requester response back-pressure.
REQ-012 rq_done  output  NREQ  one-cycle pulse when the granted burst completes.
REQ-013 agu_req_valid, agu_vl[VL_W], agu_vr[5], agu_masked, agu_s_value  outputs  request to the AGU.
REQ-014 agu_req_ready, agu_resp_valid  inputs  AGU handshake.
REQ-015 agu_resp_ready  output  1  rq_resp_ready of the granted requester; 0 when none is granted.
REQ-016 grant_id  output  2  index of the current owner; busy  output  1  high outside IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE and BUSY.
REQ-018 IDLE: if any rq_valid is high, pick the requester per REQ-021, latch its vl, vr, masked and s_value into registers, set grant_id, and go to ISSUE the next cycle; otherwise stay in IDLE.
REQ-019 ISSUE: assert agu_req_valid from the latched fields; on agu_req_valid & agu_req_ready, pulse rq_ready[grant] for exactly one cycle and go to BUSY.
REQ-020 BUSY: agu_req_valid = 0; route agu_resp_valid/agu_resp_ready per REQ-010/REQ-015; when agu_req_ready = 1, pulse rq_done[grant], advance the pointer and go to IDLE.
REQ-021 Arbitration SHALL be round-robin: search starts at the pointer and wraps modulo NREQ; after each done the pointer = grant+1 mod NREQ.
REQ-022 Latency SHALL be: rq_valid high in IDLE at cycle 0 -> agu_req_valid at cycle 1; minimum grant-to-grant overhead 2 cycles after the AGU returns ready.
REQ-023 Latched fields SHALL stay stable from ISSUE through BUSY; requester input changes after latching are ignored.
REQ-024 Deasserting rq_valid during ISSUE SHALL NOT cancel the issue.
REQ-025 A requester SHALL NOT be re-granted before its rq_done pulse.
REQ-026 rq_done and rq_ready SHALL never pulse in the same cycle.
REQ-027 Requests with vl = 0 SHALL be forwarded unchanged; the AGU defines their behaviour.
REQ-028 All outputs SHALL be registered, except the resp routing, which is combinational from grant_id.

Reset
REQ-029 On rst: state=IDLE, pointer=0, grant_id=0, latched fields 0, agu_req_valid=0, rq_ready=0, rq_done=0, busy=0.
REQ-030 rst asserted mid-burst SHALL abandon the burst with no rq_done pulse; the AGU is reset on the same rst.

Structure
REQ-031 Shared package vreg_agu_pkg SHALL hold the state enum, NREQ, VL_W and the requester-ID constants.
REQ-032 A single sub-module rr_pick (combinational round-robin picker: request vector + pointer -> one-hot grant + index) SHALL be instantiated.

Verification
REQ-033 Single request on req1 (vl=20, vr=3): agu_vl=20, agu_vr=3 at cycle 1; rq_ready[1] pulses on the handshake; rq_done[1] pulses when agu_req_ready rises; grant_id=1.
REQ-034 All three requesters held valid: grants in order 0,1,2,0 with one rq_done per grant and no requester skipped.
REQ-035 Requester inputs change during BUSY: agu_vl and agu_vr hold their latched values.
REQ-036 Response routing with grant=2 and agu_resp_valid=1: only rq_resp_valid[2]=1; agu_resp_ready follows rq_resp_ready[2] exactly.
REQ-037 rst pulsed mid-BUSY: all outputs return to REQ-029 values next cycle; no rq_done pulse; a new request is then granted starting at requester 0.
REQ-038 rq_valid[0] dropped during ISSUE: the issue still completes with rq_ready[0] and rq_done[0] pulses.
